// File: rtl/imem_loader.sv
// Boot loader: unpacks a framed little-endian byte stream into 32-bit instruction words and holds the core in reset until the image is complete.
// Optional checksum byte and XOR accumulator are enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  // State entered once the payload has been fully consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_FRAME_END = S_CHK;
`else
  localparam state_e S_FRAME_END = S_DONE;
`endif

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_e                  state_q, state_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             word_cnt_q, word_cnt_d;
  logic [1:0]              lane_q, lane_d;
  logic [23:0]             asm_q, asm_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              chk_q, chk_d;
`endif
  logic                    accept;
  logic [15:0]             len_in;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                      in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign len_in = {in_byte, len_lo_q};

  // NOTE: every *_d gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          word_cnt_d = '0;
          lane_d     = '0;
          asm_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_byte;
          state_d  = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d = len_in;
          if ({1'b0, len_in} > DEPTH_L) begin
            state_d = S_ERR;
          end else if (len_in == 16'd0) begin
            state_d = S_FRAME_END;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ in_byte;
`endif
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Earlier bytes sit in asm_q[23:0] in arrival order, low byte at the bottom.
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_WIDTH'(word_cnt_q);
            mem_wdata_d = {in_byte, asm_q};
            word_cnt_d  = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == len_q) begin
              state_d = S_FRAME_END;
            end
          end else begin
            asm_d = {in_byte, asm_q[23:8]};
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (in_byte == chk_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state, including the datapath registers, is reset so the outputs are defined from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      lane_q      <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = in_ready;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign core_rst  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-position model of the frame predicts every output each cycle.
// Works with and without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  logic [7:0]      tx_q[$];
  logic [AW+31:0]  wr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Frame model: tracks only the position of the accepted byte within the frame.
  typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_e;
  mode_e         m_mode = M_IDLE;
  int            m_pos, m_n, k;
  logic [7:0]    m_xor;
  logic [31:0]   m_word;
  logic          e_we   = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE;
      e_we   = 1'b0;
      e_addr = '0;
      e_data = '0;
    end else begin
      e_we = 1'b0;
      if (m_mode != M_LOAD) begin
        if (start) begin
          m_mode = M_LOAD;
          m_pos  = 0;
          m_xor  = 8'h00;
        end
      end else if (in_valid) begin
        if (m_pos == 0) begin
          m_n = int'(in_byte);
        end else if (m_pos == 1) begin
          m_n = m_n + 256 * int'(in_byte);
          if (m_n > DEPTH)          m_mode = M_ERR;
          else if (m_n == 0 && !CK) m_mode = M_DONE;
        end else if (m_pos < 2 + 4 * m_n) begin
          k = m_pos - 2;
          m_word[8*(k%4) +: 8] = in_byte;
          m_xor = m_xor ^ in_byte;
          if (k % 4 == 3) begin
            e_we   = 1'b1;
            e_addr = AW'(k / 4);
            e_data = m_word;
            if (k / 4 == m_n - 1 && !CK) m_mode = M_DONE;
          end
        end else begin
          m_mode = (in_byte == m_xor) ? M_DONE : M_ERR;
        end
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("status{rdy,busy,done,err,crst,we}",
            64'({in_ready, busy, done, err, core_rst, mem_we}),
            64'({m_mode == M_LOAD, m_mode == M_LOAD, m_mode == M_DONE,
                 m_mode == M_ERR, m_mode != M_DONE, e_we}));
      check("mem_addr", 64'(mem_addr), 64'(e_addr));
      if (e_we) check("mem_wdata", 64'(mem_wdata), 64'(e_data));
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready=%b want 1", b, in_ready);
    end
  endtask

  task automatic send_all(input bit stall);
    foreach (tx_q[i]) begin
      if (stall && i > 0) idle(1);
      send(tx_q[i]);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic push_chk(input bit flip);
    logic [7:0] x = 8'h00;
    for (int i = 2; i < tx_q.size(); i++) x = x ^ tx_q[i];
    tx_q.push_back(flip ? (x ^ 8'h01) : x);
  endtask
`endif

  task automatic build_frame1();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_chk(1'b0);
`endif
  endtask

  task automatic check_frame1(input string tag);
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(0));
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(2));
    if (wr_q.size() == 2) begin
      check({tag, "_w0"}, 64'(wr_q[0]), 64'({8'h00, 32'h0000_0013}));
      check({tag, "_w1"}, 64'(wr_q[1]), 64'({8'h01, 32'h0010_0093}));
    end
  endtask

  function automatic logic [31:0] depth_word(input int i);
    return {8'(i), 8'(255 - i), 8'(i) ^ 8'h5A, 8'hA5};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("rst_core_rst", 64'(core_rst), 64'(1));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_done",     64'(done),     64'(0));
    check("rst_mem_we",   64'(mem_we),   64'(0));

    // in_valid without start consumes nothing
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'h5A;
    end
    idle(2);
    check("hold_busy",    64'(busy),        64'(0));
    check("hold_nwrites", 64'(wr_q.size()), 64'(0));

    // full-rate frame
    wr_q.delete();
    pulse_start();
    build_frame1();
    send_all(1'b0);
    idle(3);
    check_frame1("full");

    // stalled frame, valid toggles every other cycle
    wr_q.delete();
    pulse_start();
    build_frame1();
    send_all(1'b1);
    idle(3);
    check_frame1("stall");

    // oversize length
    wr_q.delete();
    pulse_start();
    tx_q = '{8'h01, 8'h01};
    send_all(1'b0);
    idle(2);
    check("big_err",      64'(err),         64'(1));
    check("big_core_rst", 64'(core_rst),    64'(1));
    check("big_nwrites",  64'(wr_q.size()), 64'(0));

    // restart after error, empty image
    pulse_start();
    idle(1);
    check("restart_busy", 64'(busy), 64'(1));
    check("restart_err",  64'(err),  64'(0));
    tx_q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_chk(1'b0);
`endif
    send_all(1'b0);
    idle(2);
    check("n0_done",    64'(done),        64'(1));
    check("n0_nwrites", 64'(wr_q.size()), 64'(0));

    // single word
    wr_q.delete();
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
`endif
    send_all(1'b0);
    idle(2);
    check("n1_done", 64'(done), 64'(1));
    check("n1_nwrites", 64'(wr_q.size()), 64'(1));
    if (wr_q.size() == 1) check("n1_w0", 64'(wr_q[0]), 64'({8'h00, 32'hDDCC_BBAA}));

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
    send_all(1'b0);
    idle(2);
    check("badchk_err",      64'(err),      64'(1));
    check("badchk_core_rst", 64'(core_rst), 64'(1));
`endif

    // maximum length fills every address
    wr_q.delete();
    pulse_start();
    tx_q = '{8'h00, 8'h01};
    for (int i = 0; i < DEPTH; i++) begin
      w = depth_word(i);
      for (int b = 0; b < 4; b++) tx_q.push_back(w[8*b +: 8]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_chk(1'b0);
`endif
    send_all(1'b0);
    idle(3);
    check("max_done",    64'(done),        64'(1));
    check("max_nwrites", 64'(wr_q.size()), 64'(DEPTH));
    if (wr_q.size() == DEPTH) begin
      check("max_first", 64'(wr_q[0]),   64'({8'h00, depth_word(0)}));
      check("max_last",  64'(wr_q[255]), 64'({8'hFF, depth_word(255)}));
    end

    // reset mid-word
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00};
    send_all(1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",     64'(busy),      64'(0));
    check("midrst_in_ready", 64'(in_ready),  64'(0));
    check("midrst_core_rst", 64'(core_rst),  64'(1));
    check("midrst_mem_addr", 64'(mem_addr),  64'(0));
    check("midrst_mem_we",   64'(mem_we),    64'(0));
    check("midrst_wdata",    64'(mem_wdata), 64'(0));

    wr_q.delete();
    pulse_start();
    build_frame1();
    send_all(1'b0);
    idle(3);
    check_frame1("after_rst");

    // start in DONE reasserts core reset
    pulse_start();
    idle(1);
    check("redo_core_rst", 64'(core_rst), 64'(1));
    check("redo_done",     64'(done),     64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
